// File: rtl/ddr3_avl_arbiter.sv
// ddr3_avl_arbiter
// Shares the DDR3 controller's Avalon-MM command port between the frame read
// master and the frame write master. Round-robin between the two, with write
// bursts never split and ownership held for up to MAX_HOLD commands or bursts
// while the other master waits.
// Optional feature macro: ARB_PERF_COUNT_EN adds perf_clear and the
// perf_rd_cmds / perf_wr_beats / perf_stall_cycles counters.
module ddr3_avl_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int ADDR_W   = 26,
    parameter int DATA_W   = 128
) (
    input  logic                ddr3_clk,
    input  logic                ddr3_reset_n,
    // read master
    input  logic                rd_avl_read_req,
    input  logic                rd_avl_burstbegin,
    input  logic [ADDR_W-1:0]   rd_avl_addr,
    input  logic [2:0]          rd_avl_size,
    output logic                rd_avl_ready,
    output logic                rd_avl_read_data_valid,
    output logic [DATA_W-1:0]   rd_avl_read_data,
    // write master
    input  logic                wr_avl_write_req,
    input  logic                wr_avl_burstbegin,
    input  logic [ADDR_W-1:0]   wr_avl_addr,
    input  logic [2:0]          wr_avl_size,
    input  logic [DATA_W-1:0]   wr_avl_wdata,
    input  logic [DATA_W/8-1:0] wr_avl_be,
    output logic                wr_avl_ready,
    // DDR3 controller
    input  logic                ddr3_avl_ready,
    output logic                ddr3_avl_burstbegin,
    output logic                ddr3_avl_read_req,
    output logic                ddr3_avl_write_req,
    output logic [ADDR_W-1:0]   ddr3_avl_addr,
    output logic [2:0]          ddr3_avl_size,
    output logic [DATA_W-1:0]   ddr3_avl_wdata,
    output logic [DATA_W/8-1:0] ddr3_avl_be,
    input  logic                ddr3_avl_read_data_valid,
    input  logic [DATA_W-1:0]   ddr3_avl_read_data,
    output logic [1:0]          grant
`ifdef ARB_PERF_COUNT_EN
    ,
    input  logic                perf_clear,
    output logic [31:0]         perf_rd_cmds,
    output logic [31:0]         perf_wr_beats,
    output logic [31:0]         perf_stall_cycles
`endif
);

    localparam int BE_W   = DATA_W / 8;
    localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    // State encoding doubles as the one-hot grant vector.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        OWN_RD = 2'b01,
        OWN_WR = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [2:0]         beat_cnt_q, beat_cnt_d;
    logic               last_wr_q, last_wr_d;   // 1: write master owned last

    logic               rd_accept;
    logic               wr_accept;
    logic               burst_done;
    logic [2:0]         size_m1;

    assign rd_accept = (state_q == OWN_RD) && rd_avl_read_req && ddr3_avl_ready;
    assign wr_accept = (state_q == OWN_WR) && wr_avl_write_req && ddr3_avl_ready;

    // A size of 0 is treated as a single-beat burst.
    assign size_m1 = (wr_avl_size == 3'd0) ? 3'd0 : wr_avl_size - 3'd1;

    // beat_cnt == 0 means no burst is open, so the accepted beat starts one.
    assign burst_done = wr_accept &&
                        ((beat_cnt_q == 3'd0) ? (size_m1 == 3'd0) : (beat_cnt_q == 3'd1));

    assign grant = state_q;

    // Read data returns straight to the read master regardless of ownership.
    assign rd_avl_read_data_valid = ddr3_avl_read_data_valid;
    assign rd_avl_read_data       = ddr3_avl_read_data;

    // Next-state: arbitration in IDLE, hold/burst tracking while owned.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        beat_cnt_d = beat_cnt_q;
        last_wr_d  = last_wr_q;
        case (state_q)
            IDLE: begin
                hold_cnt_d = '0;
                beat_cnt_d = '0;
                if (rd_avl_read_req && wr_avl_write_req) begin
                    state_d = last_wr_q ? OWN_RD : OWN_WR;
                end else if (rd_avl_read_req) begin
                    state_d = OWN_RD;
                end else if (wr_avl_write_req) begin
                    state_d = OWN_WR;
                end
            end
            OWN_RD: begin
                if (rd_accept) begin
                    if ((hold_cnt_q == HOLD_LAST) && wr_avl_write_req) begin
                        state_d   = IDLE;
                        last_wr_d = 1'b0;
                    end else if (hold_cnt_q != HOLD_LAST) begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end else if (!rd_avl_read_req) begin
                    state_d   = IDLE;
                    last_wr_d = 1'b0;
                end
            end
            OWN_WR: begin
                if (wr_accept) begin
                    beat_cnt_d = (beat_cnt_q == 3'd0) ? size_m1 : beat_cnt_q - 3'd1;
                    // Hold limit and the read request only matter between bursts.
                    if (burst_done) begin
                        if ((hold_cnt_q == HOLD_LAST) && rd_avl_read_req) begin
                            state_d   = IDLE;
                            last_wr_d = 1'b1;
                        end else if (hold_cnt_q != HOLD_LAST) begin
                            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                        end
                    end
                end else if ((beat_cnt_q == 3'd0) && !wr_avl_write_req) begin
                    // A writer that drops req mid-burst keeps the grant.
                    state_d   = IDLE;
                    last_wr_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge ddr3_clk or negedge ddr3_reset_n) begin
        if (!ddr3_reset_n) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            beat_cnt_q <= '0;
            last_wr_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            last_wr_q  <= last_wr_d;
        end
    end

    // Downstream command mux and per-master ready, qualified by the grant.
    always_comb begin
        ddr3_avl_burstbegin = 1'b0;
        ddr3_avl_read_req   = 1'b0;
        ddr3_avl_write_req  = 1'b0;
        ddr3_avl_addr       = '0;
        ddr3_avl_size       = '0;
        ddr3_avl_wdata      = '0;
        ddr3_avl_be         = {BE_W{1'b0}};
        rd_avl_ready        = 1'b0;
        wr_avl_ready        = 1'b0;
        case (state_q)
            OWN_RD: begin
                ddr3_avl_burstbegin = rd_avl_burstbegin;
                ddr3_avl_read_req   = rd_avl_read_req;
                ddr3_avl_addr       = rd_avl_addr;
                ddr3_avl_size       = rd_avl_size;
                rd_avl_ready        = ddr3_avl_ready;
            end
            OWN_WR: begin
                ddr3_avl_burstbegin = wr_avl_burstbegin;
                ddr3_avl_write_req  = wr_avl_write_req;
                ddr3_avl_addr       = wr_avl_addr;
                ddr3_avl_size       = wr_avl_size;
                ddr3_avl_wdata      = wr_avl_wdata;
                ddr3_avl_be         = wr_avl_be;
                wr_avl_ready        = ddr3_avl_ready;
            end
            default: begin
            end
        endcase
    end

`ifdef ARB_PERF_COUNT_EN
    logic [31:0] perf_rd_cmds_q, perf_rd_cmds_d;
    logic [31:0] perf_wr_beats_q, perf_wr_beats_d;
    logic [31:0] perf_stall_cycles_q, perf_stall_cycles_d;
    logic        stall;

    assign stall = (((state_q == OWN_RD) && rd_avl_read_req) ||
                    ((state_q == OWN_WR) && wr_avl_write_req)) && !ddr3_avl_ready;

    // Performance counters: free-running wrap, clear has priority.
    always_comb begin
        perf_rd_cmds_d      = perf_rd_cmds_q + {31'd0, rd_accept};
        perf_wr_beats_d     = perf_wr_beats_q + {31'd0, wr_accept};
        perf_stall_cycles_d = perf_stall_cycles_q + {31'd0, stall};
        if (perf_clear) begin
            perf_rd_cmds_d      = '0;
            perf_wr_beats_d     = '0;
            perf_stall_cycles_d = '0;
        end
    end

    // Performance counter registers.
    always_ff @(posedge ddr3_clk or negedge ddr3_reset_n) begin
        if (!ddr3_reset_n) begin
            perf_rd_cmds_q      <= '0;
            perf_wr_beats_q     <= '0;
            perf_stall_cycles_q <= '0;
        end else begin
            perf_rd_cmds_q      <= perf_rd_cmds_d;
            perf_wr_beats_q     <= perf_wr_beats_d;
            perf_stall_cycles_q <= perf_stall_cycles_d;
        end
    end

    assign perf_rd_cmds      = perf_rd_cmds_q;
    assign perf_wr_beats     = perf_wr_beats_q;
    assign perf_stall_cycles = perf_stall_cycles_q;
`endif

endmodule

// File: tb/tb_ddr3_avl_arbiter.sv
// Self-checking bench for ddr3_avl_arbiter: directed scenarios with randomized
// data/addresses/ready, checked against a transaction-level ownership model.
module tb_ddr3_avl_arbiter;

    localparam int MAX_HOLD = 16;
    localparam int ADDR_W   = 26;
    localparam int DATA_W   = 128;
    localparam int BE_W     = DATA_W / 8;
    localparam int DN_W     = 3 + ADDR_W + 3 + DATA_W + BE_W + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              rd_req = 0, rd_bb = 0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [2:0]        rd_size = '0;
    logic              wr_req = 0, wr_bb = 0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [2:0]        wr_size = '0;
    logic [DATA_W-1:0] wr_wdata = '0;
    logic [BE_W-1:0]   wr_be = '0;
    logic              dready = 0;
    logic              rdv = 0;
    logic [DATA_W-1:0] rdata = '0;

    logic              rd_avl_ready, rd_avl_read_data_valid, wr_avl_ready;
    logic [DATA_W-1:0] rd_avl_read_data;
    logic              ddr3_avl_burstbegin, ddr3_avl_read_req, ddr3_avl_write_req;
    logic [ADDR_W-1:0] ddr3_avl_addr;
    logic [2:0]        ddr3_avl_size;
    logic [DATA_W-1:0] ddr3_avl_wdata;
    logic [BE_W-1:0]   ddr3_avl_be;
    logic [1:0]        grant;
`ifdef ARB_PERF_COUNT_EN
    logic              perf_clear = 0;
    logic [31:0]       perf_rd_cmds, perf_wr_beats, perf_stall_cycles;
`endif

    ddr3_avl_arbiter #(.MAX_HOLD(MAX_HOLD), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .ddr3_clk                 (clk),
        .ddr3_reset_n             (rst_n),
        .rd_avl_read_req          (rd_req),
        .rd_avl_burstbegin        (rd_bb),
        .rd_avl_addr              (rd_addr),
        .rd_avl_size              (rd_size),
        .rd_avl_ready             (rd_avl_ready),
        .rd_avl_read_data_valid   (rd_avl_read_data_valid),
        .rd_avl_read_data         (rd_avl_read_data),
        .wr_avl_write_req         (wr_req),
        .wr_avl_burstbegin        (wr_bb),
        .wr_avl_addr              (wr_addr),
        .wr_avl_size              (wr_size),
        .wr_avl_wdata             (wr_wdata),
        .wr_avl_be                (wr_be),
        .wr_avl_ready             (wr_avl_ready),
        .ddr3_avl_ready           (dready),
        .ddr3_avl_burstbegin      (ddr3_avl_burstbegin),
        .ddr3_avl_read_req        (ddr3_avl_read_req),
        .ddr3_avl_write_req       (ddr3_avl_write_req),
        .ddr3_avl_addr            (ddr3_avl_addr),
        .ddr3_avl_size            (ddr3_avl_size),
        .ddr3_avl_wdata           (ddr3_avl_wdata),
        .ddr3_avl_be              (ddr3_avl_be),
        .ddr3_avl_read_data_valid (rdv),
        .ddr3_avl_read_data       (rdata),
        .grant                    (grant)
`ifdef ARB_PERF_COUNT_EN
        ,
        .perf_clear               (perf_clear),
        .perf_rd_cmds             (perf_rd_cmds),
        .perf_wr_beats            (perf_wr_beats),
        .perf_stall_cycles        (perf_stall_cycles)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Ownership model: who owns the port (0 none, 1 read, 2 write), who owned
    // it last, how many commands/bursts this ownership has done, beats left.
    int m_owner = 0, m_last = 2, m_count = 0, m_left = 0;

    logic [DN_W-1:0] dn_act;
    assign dn_act = {ddr3_avl_burstbegin, ddr3_avl_read_req, ddr3_avl_write_req, ddr3_avl_addr,
                     ddr3_avl_size, ddr3_avl_wdata, ddr3_avl_be, rd_avl_ready, wr_avl_ready};

    function automatic logic [1:0] exp_grant();
        return (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
    endfunction

    function automatic logic [DN_W-1:0] exp_dn();
        logic [DN_W-1:0] e;
        e = '0;
        if (m_owner == 1)
            e = {rd_bb, rd_req, 1'b0, rd_addr, rd_size, {DATA_W{1'b0}}, {BE_W{1'b0}}, dready, 1'b0};
        else if (m_owner == 2)
            e = {wr_bb, 1'b0, wr_req, wr_addr, wr_size, wr_wdata, wr_be, 1'b0, dready};
        return e;
    endfunction

    // Advance the ownership model by one clock using the inputs presented now.
    task automatic model_step();
        if (!rst_n) begin
            m_owner = 0; m_last = 2; m_count = 0; m_left = 0;
            return;
        end
        case (m_owner)
            0: begin
                m_count = 0; m_left = 0;
                if (rd_req && wr_req) m_owner = (m_last == 2) ? 1 : 2;
                else if (rd_req)      m_owner = 1;
                else if (wr_req)      m_owner = 2;
            end
            1: begin
                if (rd_req && dready) begin
                    m_count++;
                    if (m_count >= MAX_HOLD && wr_req) begin m_owner = 0; m_last = 1; end
                end else if (!rd_req) begin
                    m_owner = 0; m_last = 1;
                end
            end
            default: begin
                if (wr_req && dready) begin
                    if (m_left == 0) m_left = (wr_size == 3'd0) ? 1 : int'(wr_size);
                    m_left--;
                    if (m_left == 0) begin
                        m_count++;
                        if (m_count >= MAX_HOLD && rd_req) begin m_owner = 0; m_last = 2; end
                    end
                end else if (m_left == 0 && !wr_req) begin
                    m_owner = 0; m_last = 2;
                end
            end
        endcase
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0; rd_req = 0; wr_req = 0; rd_bb = 0; wr_bb = 0; rdv = 0; dready = 1;
        repeat (2) tick();
        rst_n = 1;
    endtask

    task automatic test_reset();
        rd_req = 1; wr_req = 1; rd_bb = 1; wr_bb = 1; dready = 1;
        rd_addr = ADDR_W'($urandom); wr_addr = ADDR_W'($urandom); wr_size = 3'd2;
        wr_wdata = {$urandom, $urandom, $urandom, $urandom};
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b want 00", grant); end
            n_checks++;
            if (dn_act !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", dn_act); end
            tick();
        end
        rst_n = 1;
        #1;
        n_checks++;
        if (grant !== 2'b00) begin n_fail++; $display("FAIL reset_release_grant: got %b want 00", grant); end
        tick();
        n_checks++;
        if (grant !== 2'b01) begin n_fail++; $display("FAIL first_tie_read: got %b want 01", grant); end
        do_reset();
    endtask

    task automatic test_read_only();
        logic [ADDR_W-1:0] addrs[4];
        logic [ADDR_W-1:0] got[$];
        int idx;
        addrs[0] = 0; addrs[1] = 4; addrs[2] = 8; addrs[3] = 12;
        idx = 0;
        dready = 1; wr_req = 0; rd_req = 1; rd_bb = 1;
        rd_size = 3'($urandom_range(1, 4));
        for (int c = 0; c < 30 && idx < 4; c++) begin
            rd_addr = addrs[idx];
            #1;
            n_checks++;
            if (grant !== exp_grant()) begin n_fail++; $display("FAIL rdonly_grant: got %b want %b", grant, exp_grant()); end
            n_checks++;
            if (dn_act !== exp_dn()) begin n_fail++; $display("FAIL rdonly_mux: got %h want %h", dn_act, exp_dn()); end
            n_checks++;
            if (wr_avl_ready !== 1'b0) begin n_fail++; $display("FAIL rdonly_wr_ready: got %b want 0", wr_avl_ready); end
            if (c == 0) begin
                n_checks++;
                if (grant !== 2'b00) begin n_fail++; $display("FAIL rdonly_latency0: got %b want 00", grant); end
            end
            if (c == 1) begin
                n_checks++;
                if (grant !== 2'b01) begin n_fail++; $display("FAIL rdonly_latency1: got %b want 01", grant); end
            end
            if (rd_avl_ready && rd_req) begin got.push_back(ddr3_avl_addr); idx++; end
            tick();
        end
        rd_req = 0;
        n_checks++;
        if (got.size() != 4) begin n_fail++; $display("FAIL rdonly_count: got %0d want 4", got.size()); end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== addrs[i]) begin n_fail++; $display("FAIL rdonly_addr%0d: got %0d want %0d", i, got[i], addrs[i]); end
        end
        repeat (2) tick();
        n_checks++;
        if (grant !== 2'b00) begin n_fail++; $display("FAIL rdonly_release: got %b want 00", grant); end
    endtask

    task automatic test_write_rd_interrupt();
        logic [DATA_W-1:0] wd[4];
        logic [BE_W-1:0]   wb[4];
        int beat, first_acc, last_acc, zero_cnt;
        bit rd_done;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wd[i] = {$urandom, $urandom, $urandom, $urandom};
            wb[i] = BE_W'($urandom);
        end
        wr_addr = ADDR_W'($urandom); wr_size = 3'd4; dready = 1;
        rd_addr = ADDR_W'($urandom); rd_bb = 1; rd_size = 3'd1;
        beat = 0; first_acc = -1; last_acc = -1; zero_cnt = 0; rd_done = 0;
        for (int c = 0; c < 40 && !rd_done; c++) begin
            wr_req = (beat < 4); wr_bb = (beat == 0);
            if (beat < 4) begin wr_wdata = wd[beat]; wr_be = wb[beat]; end
            else begin wr_wdata = '0; wr_be = '0; end
            rd_req = (beat >= 1);
            #1;
            n_checks++;
            if (grant !== exp_grant()) begin n_fail++; $display("FAIL wrint_grant: got %b want %b", grant, exp_grant()); end
            n_checks++;
            if (dn_act !== exp_dn()) begin n_fail++; $display("FAIL wrint_mux: got %h want %h", dn_act, exp_dn()); end
            if (beat == 4 && grant == 2'b00) zero_cnt++;
            if (wr_avl_ready && wr_req) begin
                n_checks++;
                if (ddr3_avl_wdata !== wd[beat] || ddr3_avl_be !== wb[beat]) begin
                    n_fail++; $display("FAIL wrint_beat%0d: got %h want %h", beat, ddr3_avl_wdata, wd[beat]);
                end
                if (beat == 0) first_acc = c;
                if (beat == 3) last_acc = c;
                beat++;
            end
            if (rd_avl_ready && rd_req) rd_done = 1;
            tick();
        end
        rd_req = 0; wr_req = 0;
        n_checks++;
        if (beat != 4) begin n_fail++; $display("FAIL wrint_beats: got %0d want 4", beat); end
        n_checks++;
        if (last_acc - first_acc != 3) begin n_fail++; $display("FAIL wrint_contiguous: got span %0d want 3", last_acc - first_acc); end
        n_checks++;
        if (zero_cnt != 1) begin n_fail++; $display("FAIL wrint_dead_cycles: got %0d want 1", zero_cnt); end
        n_checks++;
        if (!rd_done) begin n_fail++; $display("FAIL wrint_read_granted: got 0 want 1"); end
    endtask

    task automatic test_both_continuous();
        int wbeat, wsize, first_owner, run_cnt, runs_done;
        bit new_burst, new_rd;
        logic [1:0] prev_g;
        do_reset();
        first_owner = 0; run_cnt = 0; runs_done = 0; prev_g = 2'b00;
        wbeat = 0; new_burst = 1; new_rd = 1; wsize = 1;
        rd_req = 1; wr_req = 1; rd_bb = 1;
        for (int c = 0; c < 600; c++) begin
            if (new_rd) begin rd_addr = ADDR_W'($urandom); rd_size = 3'($urandom_range(1, 4)); new_rd = 0; end
            if (new_burst) begin wsize = $urandom_range(1, 4); wr_addr = ADDR_W'($urandom); new_burst = 0; end
            wr_size = 3'(wsize); wr_bb = (wbeat == 0);
            wr_wdata = {$urandom, $urandom, $urandom, $urandom}; wr_be = BE_W'($urandom);
            dready = ($urandom_range(0, 5) != 0);
            #1;
            n_checks++;
            if (grant !== exp_grant()) begin n_fail++; $display("FAIL both_grant c%0d: got %b want %b", c, grant, exp_grant()); end
            n_checks++;
            if (dn_act !== exp_dn()) begin n_fail++; $display("FAIL both_mux c%0d: got %h want %h", c, dn_act, exp_dn()); end
            if (first_owner == 0 && grant != 2'b00) first_owner = int'(grant);
            if (grant != prev_g) begin
                if (prev_g != 2'b00) begin
                    n_checks++;
                    if (run_cnt != MAX_HOLD) begin n_fail++; $display("FAIL both_run_len: got %0d want %0d", run_cnt, MAX_HOLD); end
                    runs_done++;
                end
                run_cnt = 0;
            end
            if (rd_avl_ready && rd_req) begin run_cnt++; new_rd = 1; end
            if (wr_avl_ready && wr_req) begin
                wbeat++;
                if (wbeat == wsize) begin run_cnt++; wbeat = 0; new_burst = 1; end
            end
            prev_g = grant;
            tick();
        end
        rd_req = 0; wr_req = 0;
        n_checks++;
        if (first_owner != 1) begin n_fail++; $display("FAIL both_first_owner: got %0d want 1", first_owner); end
        n_checks++;
        if (runs_done < 4) begin n_fail++; $display("FAIL both_alternations: got %0d want >=4", runs_done); end
    endtask

    task automatic test_ready_stall();
        logic [DATA_W-1:0] wd[4];
        int beat, stall_left, first_acc, last_acc;
        do_reset();
        for (int i = 0; i < 4; i++) wd[i] = {$urandom, $urandom, $urandom, $urandom};
        wr_addr = ADDR_W'($urandom); wr_size = 3'd4; wr_be = '1;
        beat = 0; stall_left = 5; first_acc = -1; last_acc = -1;
        for (int c = 0; c < 40 && beat < 4; c++) begin
            wr_req = 1; wr_bb = (beat == 0); wr_wdata = wd[beat];
            dready = !(beat == 2 && stall_left > 0);
            #1;
            n_checks++;
            if (grant !== exp_grant()) begin n_fail++; $display("FAIL stall_grant: got %b want %b", grant, exp_grant()); end
            n_checks++;
            if (dn_act !== exp_dn()) begin n_fail++; $display("FAIL stall_mux: got %h want %h", dn_act, exp_dn()); end
            if (!dready) begin
                n_checks++;
                if (wr_avl_ready !== 1'b0 || grant !== 2'b10) begin
                    n_fail++; $display("FAIL stall_hold: got ready %b grant %b want 0 10", wr_avl_ready, grant);
                end
                stall_left--;
            end
            if (wr_avl_ready && wr_req) begin
                n_checks++;
                if (ddr3_avl_wdata !== wd[beat]) begin n_fail++; $display("FAIL stall_beat%0d: got %h want %h", beat, ddr3_avl_wdata, wd[beat]); end
                if (beat == 0) first_acc = c;
                if (beat == 3) last_acc = c;
                beat++;
            end
            tick();
        end
        wr_req = 0; dready = 1;
        n_checks++;
        if (last_acc - first_acc != 8) begin n_fail++; $display("FAIL stall_span: got %0d want 8", last_acc - first_acc); end
        repeat (2) tick();
        n_checks++;
        if (grant !== 2'b00) begin n_fail++; $display("FAIL stall_release: got %b want 00", grant); end
    endtask

    task automatic test_rdata_passthrough();
        logic [DATA_W-1:0] a5;
        a5 = {16{8'hA5}};
        do_reset();
        wr_addr = ADDR_W'($urandom); wr_size = 3'd4; dready = 1; wr_req = 1;
        for (int c = 0; c < 8; c++) begin
            wr_bb = (c == 1); wr_wdata = {$urandom, $urandom, $urandom, $urandom};
            if (c == 2) begin rdv = 1; rdata = a5; end
            else begin rdv = 1'($urandom_range(0, 1)); rdata = {$urandom, $urandom, $urandom, $urandom}; end
            #1;
            n_checks++;
            if (rd_avl_read_data_valid !== rdv || rd_avl_read_data !== rdata) begin
                n_fail++; $display("FAIL rdata_pass c%0d: got %b %h want %b %h", c, rd_avl_read_data_valid, rd_avl_read_data, rdv, rdata);
            end
            if (c == 2) begin
                n_checks++;
                if (grant !== 2'b10 || rd_avl_read_data !== a5 || rd_avl_read_data_valid !== 1'b1) begin
                    n_fail++; $display("FAIL rdata_a5: got grant %b valid %b data %h", grant, rd_avl_read_data_valid, rd_avl_read_data);
                end
            end
            tick();
        end
        wr_req = 0; rdv = 0;
    endtask

    task automatic test_reset_mid_burst();
        int beat;
        bit hit;
        do_reset();
        wr_addr = ADDR_W'($urandom); wr_size = 3'd4; dready = 1; wr_be = '1;
        beat = 0; hit = 0;
        for (int c = 0; c < 10 && !hit; c++) begin
            wr_req = 1; wr_bb = (beat == 0); wr_wdata = {$urandom, $urandom, $urandom, $urandom};
            #1;
            if (beat == 1 && grant == 2'b10) begin
                rst_n = 0;
                #1;
                n_checks++;
                if (grant !== 2'b00) begin n_fail++; $display("FAIL rstmid_grant: got %b want 00", grant); end
                n_checks++;
                if (dn_act !== '0) begin n_fail++; $display("FAIL rstmid_outputs: got %h want 0", dn_act); end
                hit = 1;
            end else if (wr_avl_ready && wr_req) begin
                beat++;
            end
            tick();
        end
        n_checks++;
        if (!hit) begin n_fail++; $display("FAIL rstmid_reached: got 0 want 1"); end
        tick();
        rst_n = 1;
        rd_req = 1; rd_bb = 1; rd_addr = ADDR_W'($urandom); wr_bb = 1;
        #1;
        n_checks++;
        if (grant !== 2'b00) begin n_fail++; $display("FAIL rstmid_post0: got %b want 00", grant); end
        tick();
        n_checks++;
        if (grant !== 2'b01) begin n_fail++; $display("FAIL rstmid_post1: got %b want 01", grant); end
        n_checks++;
        if (dn_act !== exp_dn()) begin n_fail++; $display("FAIL rstmid_mux: got %h want %h", dn_act, exp_dn()); end
        rd_req = 0; wr_req = 0;
    endtask

`ifdef ARB_PERF_COUNT_EN
    task automatic test_perf();
        do_reset();
        #1;
        n_checks++;
        if ({perf_rd_cmds, perf_wr_beats, perf_stall_cycles} !== '0) begin
            n_fail++; $display("FAIL perf_reset: got %0d %0d %0d want 0", perf_rd_cmds, perf_wr_beats, perf_stall_cycles);
        end
        rd_req = 1; rd_bb = 1; dready = 0;
        for (int c = 0; c < 6; c++) begin
            dready = (c >= 4);
            tick();
        end
        rd_req = 0;
        tick();
        n_checks++;
        if (perf_rd_cmds !== 32'd2 || perf_stall_cycles !== 32'd3 || perf_wr_beats !== 32'd0) begin
            n_fail++; $display("FAIL perf_counts: got %0d %0d %0d want 2 0 3", perf_rd_cmds, perf_wr_beats, perf_stall_cycles);
        end
        perf_clear = 1;
        tick();
        perf_clear = 0;
        n_checks++;
        if ({perf_rd_cmds, perf_wr_beats, perf_stall_cycles} !== '0) begin
            n_fail++; $display("FAIL perf_clear: got %0d %0d %0d want 0", perf_rd_cmds, perf_wr_beats, perf_stall_cycles);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_read_only();
        test_write_rd_interrupt();
        test_both_continuous();
        test_ready_stall();
        test_rdata_passthrough();
        test_reset_mid_burst();
`ifdef ARB_PERF_COUNT_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
